// File: rtl/data_memory.sv
// Word-organised 32-bit data RAM for the CPU MEM stage.
// Writes are byte-lane masked on the rising edge; reads are combinational full words.
module data_memory #(
  parameter int MemDepth  = 1024,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           byte_slct,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o
);

  localparam int IdxWidth = $clog2(MemDepth);

  // Left uninitialised so benches can preload it from a hex image.
  logic [31:0]         mem_data [MemDepth];
  logic [IdxWidth-1:0] word_idx;
  logic                unused_addr;

  assign word_idx = addr_i[IdxWidth+1:2];

  // Byte offset and upper bits do not take part in decode; addresses alias.
  assign unused_addr = ^{addr_i[AddrWidth-1:IdxWidth+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_slct[k]) begin
          mem_data[word_idx][8*k +: 8] <= data_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    data_o = 32'h0000_0000;
    if (!rst && ce) begin
      data_o = mem_data[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected words are queued when stimulus is
// driven and popped when the combinational read is sampled.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr_i;
  logic [3:0]  byte_slct;
  logic [31:0] data_i;
  logic [31:0] data_o;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model [int];

  data_memory #(.MemDepth(1024), .AddrWidth(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .we        (we),
    .addr_i    (addr_i),
    .byte_slct (byte_slct),
    .data_i    (data_i),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] exp);
    sb_q.push_back(exp);
  endtask

  // Pop the oldest expectation and compare it against data_o.
  task automatic check_out(input string tag);
    logic [31:0] exp;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, data_o);
    end else begin
      exp = sb_q.pop_front();
      assert (data_o === exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, data_o, exp);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr_i = a; byte_slct = m; data_i = d;
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0; byte_slct = 4'h0; data_i = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr_i = a; ce = 1'b1;
    push_exp(exp);
    #1 check_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  m;
    int          w;

    rst = 1'b1; ce = 1'b1; we = 1'b0; addr_i = 32'h0; byte_slct = 4'h0; data_i = 32'h0;
    repeat (2) @(negedge clk);
    push_exp(32'h0);
    #1 check_out("reset_data_o");
    @(negedge clk);
    rst = 1'b0;

    // Full-word write then read, and ce gating
    wr(32'h10, 4'hF, 32'h1234_5678);
    idle();
    rd(32'h10, 32'h1234_5678, "full_word");
    ce = 1'b0;
    push_exp(32'h0);
    #1 check_out("ce_low_zero");

    // Byte lane merge, back-to-back writes
    wr(32'h10, 4'b1000, 32'hAA00_0000);
    wr(32'h10, 4'b0001, 32'h0000_00BB);
    idle();
    rd(32'h10, 32'hAA34_56BB, "byte_merge");

    // Halfword write, addr low bits ignored
    wr(32'h12, 4'b0011, 32'h0000_CDEF);
    idle();
    rd(32'h10, 32'hAA34_CDEF, "halfword_rd10");
    rd(32'h13, 32'hAA34_CDEF, "halfword_rd13");

    // Write with ce=0, then empty mask
    @(negedge clk); ce = 1'b0;
    wr(32'h20, 4'hF, 32'hDEAD_BEEF);
    wr(32'h20, 4'h0, 32'h0);
    idle();
    rd(32'h20, 32'hDEAD_BEEF, "ce_indep_empty_mask");

    // Reset suppresses writes and reads, keeps contents
    @(negedge clk);
    rst = 1'b1; we = 1'b1; byte_slct = 4'hF; data_i = 32'h0BAD_0BAD; addr_i = 32'h10; ce = 1'b1;
    push_exp(32'h0);
    #1 check_out("reset_hold_0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      push_exp(32'h0);
      #1 check_out("reset_hold_n");
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0; byte_slct = 4'h0;
    push_exp(32'hAA34_CDEF);
    #1 check_out("after_reset_kept");

    // Aliased address with same-cycle read/write
    @(negedge clk);
    addr_i = 32'h1000_0010; ce = 1'b1; we = 1'b1; byte_slct = 4'hF; data_i = 32'h5555_AAAA;
    push_exp(32'hAA34_CDEF);
    #1 check_out("rw_old_word");
    @(posedge clk);
    push_exp(32'h5555_AAAA);
    #1 check_out("rw_new_word");
    idle();
    rd(32'h10, 32'h5555_AAAA, "alias_rd10");

    // Random masked writes against a bench-side word model
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      wr(32'h800 + 32'(i * 4), 4'hF, d);
      model[i] = d;
    end
    for (int i = 0; i < 12; i++) begin
      w = int'($urandom_range(0, 7));
      m = 4'($urandom_range(0, 15));
      d = $urandom;
      wr(32'h800 + 32'(w * 4) + 32'($urandom_range(0, 3)), m, d);
      for (int k = 0; k < 4; k++) begin
        if (m[k]) model[w][8*k +: 8] = d[8*k +: 8];
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd(32'h800 + 32'(i * 4), model[i], "random_merge");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
